muldiv_unit: RTL and testbench

Iterative multiply/divide engine that produces the HI/LO write port traffic for MULT, MULTU, DIV and DIVU. It sits in the execute stage beside the ALU and drives the HI/LO register file's write-enable and write-data inputs. It stalls the pipeline with `busy_o` while iterating and asserts the write enables for exactly one cycle per completed operation.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO engine for MULT/MULTU/DIV/DIVU: shift-add multiply and restoring
// divide, one bit per cycle, with a single-cycle write strobe per completed op.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic              cancel_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              hi_write_enable_o,
  output logic [DATA_W-1:0] hi_write_data_o,
  output logic              lo_write_enable_o,
  output logic [DATA_W-1:0] lo_write_data_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

  logic [1:0]          state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;        // product, or remainder in the upper half
  logic [DATA_W-1:0]   mcand_q, mcand_d;    // multiplicand / divisor magnitude
  logic [DATA_W-1:0]   mplier_q, mplier_d;  // multiplier bits / dividend-then-quotient
  logic                neg_q, neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_acc, mul_res;
  logic [DATA_W:0]     div_shift, div_diff;
  logic                div_ge;
  logic [DATA_W-1:0]   div_rem, div_quo;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    // Unsigned ops have op_i[0] set, so their operands never count as negative.
    a_neg = ~op_i[0] & src_a_i[DATA_W-1];
    b_neg = ~op_i[0] & src_b_i[DATA_W-1];
    abs_a = a_neg ? -src_a_i : src_a_i;
    abs_b = b_neg ? -src_b_i : src_b_i;

    mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    mul_acc = {mul_sum, acc_q[DATA_W-1:1]};
    mul_res = neg_q ? -mul_acc : mul_acc;

    div_shift = {acc_q[2*DATA_W-1:DATA_W], mplier_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    div_ge    = ~div_diff[DATA_W];
    div_rem   = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
    div_quo   = {mplier_q[DATA_W-2:0], div_ge};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          cnt_d     = '0;
          acc_d     = '0;
          if (op_i[1]) begin
            mcand_d  = abs_b;
            mplier_d = abs_a;
            if (src_b_i == '0) begin
              state_d = S_DONE;
              hi_d    = src_a_i;
              lo_d    = '1;
            end else begin
              state_d = S_DIV;
            end
          end else begin
            mcand_d  = abs_a;
            mplier_d = abs_b;
            state_d  = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_acc;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          hi_d    = mul_res[2*DATA_W-1:DATA_W];
          lo_d    = mul_res[DATA_W-1:0];
        end
      end
      S_DIV: begin
        acc_d[2*DATA_W-1:DATA_W] = div_rem;
        mplier_d = div_quo;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          hi_d    = rem_neg_q ? -div_rem : div_rem;
          lo_d    = neg_q ? -div_quo : div_quo;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush overrides everything: back to IDLE with the result registers untouched.
    if (cancel_i) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o            = (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o            = (state_q == S_DONE) && !cancel_i;
  assign hi_write_enable_o = done_o;
  assign lo_write_enable_o = done_o;
  assign hi_write_data_o   = hi_q;
  assign lo_write_data_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected HI/LO, a monitor
// pops and compares on every write strobe.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] src_a_i = '0;
  logic [31:0] src_b_i = '0;
  logic        cancel_i = 1'b0;
  logic        busy_o, done_o, hi_we, lo_we;
  logic [31:0] hi_wd, lo_wd;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_pushed = 0;
  logic [63:0] sb_q[$];

  muldiv_unit #(.DATA_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start_i),
    .op_i              (op_i),
    .src_a_i           (src_a_i),
    .src_b_i           (src_b_i),
    .cancel_i          (cancel_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .hi_write_enable_o (hi_we),
    .hi_write_data_o   (hi_wd),
    .lo_write_enable_o (lo_we),
    .lo_write_data_o   (lo_wd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (hi_we || lo_we)) begin
      logic [63:0] exp;
      n_writes++;
      check("we_pair", {63'd0, lo_we}, {63'd0, hi_we});
      check("done_with_we", {63'd0, done_o}, 64'd1);
      check("sb_nonempty", {63'd0, sb_q.size() != 0}, 64'd1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        check("hi_data", {32'd0, hi_wd}, {32'd0, exp[63:32]});
        check("lo_data", {32'd0, lo_wd}, {32'd0, exp[31:0]});
      end
    end
  end

  // Issue one op, expect a write after exp_busy stalled cycles, then a single-cycle strobe.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_busy);
    int nb;
    bit seen;
    @(negedge clk);
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    sb_q.push_back({exp_hi, exp_lo});
    n_pushed++;
    @(posedge clk);
    #1 start_i = 1'b0;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (hi_we) begin
        seen = 1'b1;
        check("busy_low_in_done", {63'd0, busy_o}, 64'd0);
      end else if (busy_o) begin
        nb++;
      end
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    check("busy_cycles", 64'(nb), 64'(exp_busy));
    @(negedge clk);
    check("we_one_cycle", {63'd0, hi_we}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_data", {hi_wd, lo_wd}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 32);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
    run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        32);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 32);
    run_op(OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 0);
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 32);

    // Cancel during the 10th DIV iteration: no write, busy gone next cycle.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIV; src_a_i = 32'd1000; src_b_i = 32'd3;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 cancel_i = 1'b1;
    check("busy_before_cancel", {63'd0, busy_o}, 64'd1);
    @(posedge clk);
    #1 check("busy_after_cancel", {63'd0, busy_o}, 64'd0);
    cancel_i = 1'b0;
    run_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 32);

    // Cancel in the DONE cycle gates the strobe combinationally.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_MULTU; src_a_i = 32'd9; src_b_i = 32'd9;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (32) @(posedge clk);
    #1 check("done_before_cancel", {63'd0, done_o}, 64'd1);
    cancel_i = 1'b1;
    #1 check("done_gated", {63'd0, done_o}, 64'd0);
    check("hi_we_gated", {63'd0, hi_we}, 64'd0);
    check("lo_we_gated", {63'd0, lo_we}, 64'd0);
    @(posedge clk);
    #1 cancel_i = 1'b0;
    check("idle_after_cancel", {63'd0, busy_o}, 64'd0);

    // start_i held high through busy and DONE: exactly one write, operands latched at accept.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_MULTU; src_a_i = 32'd6; src_b_i = 32'd7;
    sb_q.push_back({32'd0, 32'd42});
    n_pushed++;
    @(posedge clk);
    #1 src_a_i = 32'd100; src_b_i = 32'd100; op_i = OP_DIVU;
    for (int i = 0; i < 100 && !hi_we; i++) @(negedge clk);
    check("held_start_done", {63'd0, hi_we}, 64'd1);
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("held_start_idle", {63'd0, busy_o}, 64'd0);

    // Async reset mid-MUL clears every output immediately.
    run_op(OP_MULTU, 32'd1234, 32'd1000, 32'd0, 32'd1234000, 32);
    @(negedge clk);
    start_i = 1'b1; op_i = OP_MULT; src_a_i = 32'd77; src_b_i = 32'd88;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("arst_busy", {63'd0, busy_o}, 64'd0);
    check("arst_we", {62'd0, hi_we, lo_we}, 64'd0);
    check("arst_data", {hi_wd, lo_wd}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("idle_after_reset", {63'd0, busy_o}, 64'd0);
    repeat (40) @(negedge clk);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("write_count", 64'(n_writes), 64'(n_pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
